// File: rtl/spi.sv
// Register-bus SPI slave (mode 0): command byte, address word, then a burst of data
// words, all oversampled in the i_clk domain and presented on a parallel register bus.
module spi #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_cs,
  input  logic                         i_sck,
  input  logic                         i_mosi,
  output logic                         o_miso,
  output logic [ADDRESS_BUS_WIDTH-1:0] o_address,
  output logic [7:0]                   o_command,
  output logic                         o_transaction_strobe,
  output logic [DATA_BUS_WIDTH-1:0]    o_write_data,
  input  logic [DATA_BUS_WIDTH-1:0]    i_read_data
);

  localparam int RX_W  = (ADDRESS_BUS_WIDTH > DATA_BUS_WIDTH) ? ADDRESS_BUS_WIDTH : DATA_BUS_WIDTH;
  localparam int CNT_W = $clog2(RX_W);

  typedef enum logic [1:0] {
    S_CMD,
    S_ADDR,
    S_DATA
  } state_t;

  state_t state_q, state_d;

  logic cs_meta, cs_sync;
  logic sck_meta, sck_sync, sck_prev;
  logic mosi_meta, mosi_sync;
  logic sck_rise, sck_fall;
  logic last_bit;

  logic [CNT_W-1:0]          bit_cnt;
  logic [RX_W-1:0]           rx;
  logic [DATA_BUS_WIDTH-1:0] tx;
  logic                      cmd_done, addr_done, word_done;
  logic                      first_word;
  logic                      rd_d1;

  // Two-flop synchronizers; CS idles high so it resets high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      cs_meta   <= i_cs;
      cs_sync   <= cs_meta;
      sck_meta  <= i_sck;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      mosi_meta <= i_mosi;
      mosi_sync <= mosi_meta;
    end
  end

  always_comb begin
    sck_rise = sck_sync & ~sck_prev & ~cs_sync;
    sck_fall = ~sck_sync & sck_prev & ~cs_sync;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_CMD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_bit = 1'b0;
    unique case (state_q)
      S_CMD: begin
        last_bit = (bit_cnt == CNT_W'(7));
        if (sck_rise && last_bit) state_d = S_ADDR;
      end
      S_ADDR: begin
        last_bit = (bit_cnt == CNT_W'(ADDRESS_BUS_WIDTH - 1));
        if (sck_rise && last_bit) state_d = S_DATA;
      end
      S_DATA: begin
        last_bit = (bit_cnt == CNT_W'(DATA_BUS_WIDTH - 1));
      end
      default: state_d = S_CMD;
    endcase
    if (cs_sync) state_d = S_CMD;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt              <= '0;
      rx                   <= '0;
      tx                   <= '0;
      cmd_done             <= 1'b0;
      addr_done            <= 1'b0;
      word_done            <= 1'b0;
      first_word           <= 1'b0;
      rd_d1                <= 1'b0;
      o_miso               <= 1'b0;
      o_address            <= '0;
      o_command            <= '0;
      o_write_data         <= '0;
      o_transaction_strobe <= 1'b0;
    end else begin
      o_transaction_strobe <= 1'b0;
      cmd_done             <= 1'b0;
      addr_done            <= 1'b0;
      word_done            <= 1'b0;
      rd_d1                <= o_transaction_strobe & ~o_command[0];

      if (cs_sync) begin
        bit_cnt    <= '0;
        tx         <= '0;
        o_miso     <= 1'b0;
        first_word <= 1'b0;
        rd_d1      <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx <= {rx[RX_W-2:0], mosi_sync};
          if (last_bit) begin
            bit_cnt <= '0;
            unique case (state_q)
              S_CMD:   cmd_done  <= 1'b1;
              S_ADDR:  addr_done <= 1'b1;
              S_DATA:  word_done <= 1'b1;
              default: ;
            endcase
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        if (cmd_done) o_command <= rx[7:0];

        if (addr_done) begin
          o_address  <= rx[ADDRESS_BUS_WIDTH-1:0];
          first_word <= 1'b1;
          if (!o_command[0]) o_transaction_strobe <= 1'b1;
        end

        // Reads prefetch the next word at every word boundary; writes advance the
        // address only from the second word on, so each write strobe sees its own address.
        if (word_done) begin
          first_word           <= 1'b0;
          o_transaction_strobe <= 1'b1;
          if (o_command[0]) begin
            o_write_data <= rx[DATA_BUS_WIDTH-1:0];
            if (!first_word) o_address <= o_address + ADDRESS_BUS_WIDTH'(1);
          end else begin
            o_address <= o_address + ADDRESS_BUS_WIDTH'(1);
          end
        end

        // The fall right after a word boundary must not shift: the freshly loaded MSB
        // has to survive until the master samples it on the next rise.
        if (rd_d1) begin
          tx <= i_read_data;
        end else if (sck_fall && state_q == S_DATA && bit_cnt != '0) begin
          tx <= {tx[DATA_BUS_WIDTH-2:0], 1'b0};
        end

        o_miso <= (state_q == S_DATA) ? tx[DATA_BUS_WIDTH-1] : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi.sv
// Directed bench for the spi register-bus slave: drives bit-banged mode-0 frames and
// checks bus strobes, captured command/address/data and MISO read-back.
module tb_spi;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cs;
  logic        i_sck;
  logic        i_mosi;
  logic        o_miso;
  logic [15:0] o_address;
  logic [7:0]  o_command;
  logic        o_transaction_strobe;
  logic [15:0] o_write_data;
  logic [15:0] i_read_data = 16'h0000;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  st_cmd[$];
  logic [15:0] st_addr[$];
  logic [15:0] st_data[$];
  int          strobe_runs = 0;
  logic        strobe_prev = 1'b0;
  logic        rd_arm = 1'b0;
  logic [15:0] rd_value = 16'h0000;

  always #5 i_clk = ~i_clk;

  spi #(
    .ADDRESS_BUS_WIDTH(16),
    .DATA_BUS_WIDTH   (16)
  ) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_cs                (i_cs),
    .i_sck               (i_sck),
    .i_mosi              (i_mosi),
    .o_miso              (o_miso),
    .o_address           (o_address),
    .o_command           (o_command),
    .o_transaction_strobe(o_transaction_strobe),
    .o_write_data        (o_write_data),
    .i_read_data         (i_read_data)
  );

  // Bus-side responder: logs every strobe and answers reads one clock later.
  always @(negedge i_clk) begin
    if (rd_arm) begin
      i_read_data = rd_value;
      rd_arm = 1'b0;
    end
    if (o_transaction_strobe === 1'b1) begin
      st_cmd.push_back(o_command);
      st_addr.push_back(o_address);
      st_data.push_back(o_write_data);
      if (o_command[0] == 1'b0) rd_arm = 1'b1;
      if (strobe_prev) strobe_runs++;
    end
    strobe_prev = (o_transaction_strobe === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    st_cmd.delete();
    st_addr.delete();
    st_data.delete();
  endtask

  task automatic xfer(input logic [15:0] v, input int n, input int half, output logic [15:0] m);
    m = '0;
    for (int i = n - 1; i >= 0; i--) begin
      i_mosi = v[i];
      repeat (half) @(negedge i_clk);
      m = {m[14:0], o_miso};
      i_sck = 1'b1;
      repeat (half) @(negedge i_clk);
      i_sck = 1'b0;
    end
  endtask

  task automatic cs_low(input int half);
    @(negedge i_clk);
    i_cs = 1'b0;
    repeat (half) @(negedge i_clk);
  endtask

  task automatic cs_high(input int half);
    repeat (half) @(negedge i_clk);
    i_cs = 1'b1;
    repeat (10) @(negedge i_clk);
  endtask

  initial begin
    logic [15:0] m_cmd, m_addr, m_data, m_dummy;
    int halves[2];
    int pre_data;
    halves[0] = 8;
    halves[1] = 32;

    i_rst  = 1'b1;
    i_cs   = 1'b1;
    i_sck  = 1'b0;
    i_mosi = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_miso",    32'(o_miso), 32'h0);
    check("rst_address", 32'(o_address), 32'h0);
    check("rst_command", 32'(o_command), 32'h0);
    check("rst_wdata",   32'(o_write_data), 32'h0);
    check("rst_strobe",  32'(o_transaction_strobe), 32'h0);
    repeat (100) @(negedge i_clk);
    check("idle_strobes", 32'(st_cmd.size()), 32'd0);

    for (int s = 0; s < 2; s++) begin
      // Register write 0x03 / 0x0001 / 0xABCD
      clear_log();
      cs_low(halves[s]);
      xfer(16'h0003, 8, halves[s], m_cmd);
      xfer(16'h0001, 16, halves[s], m_addr);
      xfer(16'hABCD, 16, halves[s], m_data);
      cs_high(halves[s]);
      check("wr_count", 32'(st_cmd.size()), 32'd1);
      if (st_cmd.size() >= 1) begin
        check("wr_cmd",  32'(st_cmd[0]), 32'h03);
        check("wr_addr", 32'(st_addr[0]), 32'h0001);
        check("wr_data", 32'(st_data[0]), 32'hABCD);
      end
      check("wr_hold_cmd", 32'(o_command), 32'h03);

      // Register read 0x02 / 0x0002, bus answers 0x0155
      clear_log();
      rd_value = 16'h0155;
      cs_low(halves[s]);
      xfer(16'h0002, 8, halves[s], m_cmd);
      xfer(16'h0002, 16, halves[s], m_addr);
      pre_data = st_cmd.size();
      xfer(16'hFFFF, 16, halves[s], m_data);
      cs_high(halves[s]);
      check("rd_pre_count", 32'(pre_data), 32'd1);
      if (st_cmd.size() >= 1) begin
        check("rd_cmd",  32'(st_cmd[0]), 32'h02);
        check("rd_addr", 32'(st_addr[0]), 32'h0002);
      end
      check("rd_miso_word", 32'(m_data), 32'h0155);
      check("rd_miso_cmd",  32'(m_cmd[7:0]), 32'h00);
      check("rd_miso_addr", 32'(m_addr), 32'h0000);
      check("rd_wdata_hold", 32'(o_write_data), 32'hABCD);
      check("rd_miso_idle", 32'(o_miso), 32'h0);
    end

    // Burst write with address wrap
    clear_log();
    cs_low(8);
    xfer(16'h0003, 8, 8, m_cmd);
    xfer(16'hFFFF, 16, 8, m_addr);
    xfer(16'h1111, 16, 8, m_data);
    xfer(16'h2222, 16, 8, m_data);
    cs_high(8);
    check("burst_count", 32'(st_cmd.size()), 32'd2);
    if (st_cmd.size() >= 2) begin
      check("burst_addr0", 32'(st_addr[0]), 32'hFFFF);
      check("burst_data0", 32'(st_data[0]), 32'h1111);
      check("burst_addr1", 32'(st_addr[1]), 32'h0000);
      check("burst_data1", 32'(st_data[1]), 32'h2222);
    end

    // Abort after 9 data bits, then a clean frame
    clear_log();
    cs_low(8);
    xfer(16'h0003, 8, 8, m_cmd);
    xfer(16'h0000, 16, 8, m_addr);
    xfer(16'h01A5, 9, 8, m_dummy);
    cs_high(8);
    check("abort_count", 32'(st_cmd.size()), 32'd0);
    check("abort_wdata", 32'(o_write_data), 32'h2222);

    clear_log();
    cs_low(8);
    xfer(16'h0003, 8, 8, m_cmd);
    xfer(16'h0000, 16, 8, m_addr);
    xfer(16'h00FF, 16, 8, m_data);
    cs_high(8);
    check("after_abort_count", 32'(st_cmd.size()), 32'd1);
    if (st_cmd.size() >= 1) begin
      check("after_abort_addr", 32'(st_addr[0]), 32'h0000);
      check("after_abort_data", 32'(st_data[0]), 32'h00FF);
    end

    check("strobe_width", 32'(strobe_runs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
